// File: rtl/rotate_bank_ctrl.sv
// ---------------------------------------------------------------------------
// rotate_bank_ctrl
//
// Command-driven sequencer for a ring of NREG registers, each WIDTH bits.
// One command is accepted at a time: LOAD, CLEAR, ROT_LEFT by N or ROT_RIGHT
// by N. A rotation performs one step per clock, and every register in the
// ring updates on the same edge, so no value is lost. An in-progress
// rotation can be stopped early with abort.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   cmd_valid  in   command present
//   cmd_ready  out  controller idle and able to accept a command
//   cmd_op     in   00=LOAD, 01=ROT_LEFT, 10=ROT_RIGHT, 11=CLEAR
//   cmd_steps  in   rotation count for ROT_* commands
//   load_data  in   LOAD value; register i = load_data[i*WIDTH +: WIDTH]
//   abort      in   stops a rotation in progress (ignored when not rotating)
//   reg_out    out  bank contents, packed the same way as load_data
//   busy       out  high while rotating
//   done       out  one-cycle completion pulse
//   aborted    out  qualifies done: 1 when the command ended by abort
//   steps_left out  remaining rotations (0 when not rotating)
// ---------------------------------------------------------------------------
module rotate_bank_ctrl #(
   parameter int NREG  = 3,
   parameter int WIDTH = 8,
   parameter int STEPW = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [STEPW-1:0]      cmd_steps,
   input  logic [NREG*WIDTH-1:0] load_data,
   input  logic                  abort,
   output logic [NREG*WIDTH-1:0] reg_out,
   output logic                  busy,
   output logic                  done,
   output logic                  aborted,
   output logic [STEPW-1:0]      steps_left
);

   localparam int BW = NREG * WIDTH;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ROT  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_ROTL = 2'b01;
   localparam logic [1:0] OP_ROTR = 2'b10;

   localparam logic [STEPW-1:0] STEP_ZERO = {STEPW{1'b0}};
   localparam logic [STEPW-1:0] STEP_ONE  = {{(STEPW-1){1'b0}}, 1'b1};

   logic [1:0]       state;
   logic [BW-1:0]    bank;
   logic [STEPW-1:0] steps_cnt;
   logic             dir_left;
   logic             aborted_q;

   logic [1:0]       state_nxt;
   logic [BW-1:0]    bank_nxt;
   logic [STEPW-1:0] steps_nxt;
   logic             dir_left_nxt;
   logic             aborted_nxt;

   // Register i sits at bank[i*WIDTH +: WIDTH]. A left rotation (r[i] <= r[i+1])
   // moves every field down one slot with r0 wrapping to the top; a right
   // rotation is the mirror image. Both are pure wiring of the whole ring, so
   // all registers change together.
   logic [BW-1:0] rot_left;
   logic [BW-1:0] rot_right;
   assign rot_left  = {bank[WIDTH-1:0], bank[BW-1:WIDTH]};
   assign rot_right = {bank[BW-WIDTH-1:0], bank[BW-1 -: WIDTH]};

   // Next-state and datapath decision for the command sequencer.
   always_comb begin
      state_nxt    = state;
      bank_nxt     = bank;
      steps_nxt    = steps_cnt;
      dir_left_nxt = dir_left;
      aborted_nxt  = aborted_q;
      case (state)
         ST_IDLE: begin
            if (cmd_valid) begin
               aborted_nxt = 1'b0;
               case (cmd_op)
                  OP_LOAD: begin
                     bank_nxt  = load_data;
                     state_nxt = ST_DONE;
                  end
                  OP_ROTL, OP_ROTR: begin
                     dir_left_nxt = (cmd_op == OP_ROTL);
                     if (cmd_steps == STEP_ZERO) begin
                        state_nxt = ST_DONE;
                     end else begin
                        steps_nxt = cmd_steps;
                        state_nxt = ST_ROT;
                     end
                  end
                  default: begin
                     // CLEAR
                     bank_nxt  = {BW{1'b0}};
                     state_nxt = ST_DONE;
                  end
               endcase
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_ROT: begin
            // abort takes priority, even over the final step
            if (abort) begin
               steps_nxt   = STEP_ZERO;
               aborted_nxt = 1'b1;
               state_nxt   = ST_DONE;
            end else begin
               bank_nxt  = dir_left ? rot_left : rot_right;
               steps_nxt = steps_cnt - STEP_ONE;
               if (steps_cnt == STEP_ONE) begin
                  state_nxt = ST_DONE;
               end else begin
                  state_nxt = ST_ROT;
               end
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
            steps_nxt = STEP_ZERO;
         end
      endcase
   end

   // State, bank and flag registers; handshake flags are decoded from the
   // next state so every output comes straight from a flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         bank      <= {BW{1'b0}};
         steps_cnt <= STEP_ZERO;
         dir_left  <= 1'b0;
         aborted_q <= 1'b0;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         bank      <= bank_nxt;
         steps_cnt <= steps_nxt;
         dir_left  <= dir_left_nxt;
         aborted_q <= aborted_nxt;
         cmd_ready <= (state_nxt == ST_IDLE);
         busy      <= (state_nxt == ST_ROT);
         done      <= (state_nxt == ST_DONE);
      end
   end

   assign reg_out    = bank;
   assign steps_left = steps_cnt;
   assign aborted    = aborted_q;

endmodule

// File: tb/tb_rotate_bank_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rotate_bank_ctrl
//
// Directed, table-driven bench for rotate_bank_ctrl (NREG=3, WIDTH=8,
// STEPW=4). Each table row holds the inputs for one clock and the outputs
// expected just after that edge. Reset mid-rotation and a long rotation
// with a bounded wait for done are written out by hand.
// ---------------------------------------------------------------------------
module tb_rotate_bank_ctrl;

   localparam logic [1:0] L  = 2'b00;
   localparam logic [1:0] RL = 2'b01;
   localparam logic [1:0] RR = 2'b10;
   localparam logic [1:0] CL = 2'b11;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [3:0]  cmd_steps;
   logic [23:0] load_data;
   logic        abort;
   logic [23:0] reg_out;
   logic        busy;
   logic        done;
   logic        aborted;
   logic [3:0]  steps_left;

   int n_checks;
   int n_fail;

   typedef struct {
      logic        rst;
      logic        valid;
      logic [1:0]  op;
      logic [3:0]  steps;
      logic [23:0] data;
      logic        abort;
      logic [23:0] e_reg;
      logic        e_ready;
      logic        e_busy;
      logic        e_done;
      logic        e_ab;
      logic [3:0]  e_sl;
   } vec_t;

   vec_t vecs[$];

   rotate_bank_ctrl #(.NREG(3), .WIDTH(8), .STEPW(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_steps  (cmd_steps),
      .load_data  (load_data),
      .abort      (abort),
      .reg_out    (reg_out),
      .busy       (busy),
      .done       (done),
      .aborted    (aborted),
      .steps_left (steps_left)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [23:0] pk(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2);
      return {r2, r1, r0};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic v, input logic [1:0] op, input logic [3:0] st,
                      input logic [23:0] d, input logic ab, input logic [23:0] e_reg,
                      input logic e_rdy, input logic e_busy, input logic e_done,
                      input logic e_ab, input logic [3:0] e_sl);
      vec_t t;
      t.rst = r; t.valid = v; t.op = op; t.steps = st; t.data = d; t.abort = ab;
      t.e_reg = e_reg; t.e_ready = e_rdy; t.e_busy = e_busy; t.e_done = e_done;
      t.e_ab = e_ab; t.e_sl = e_sl;
      vecs.push_back(t);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [23:0] e_reg, input logic e_rdy,
                            input logic e_busy, input logic e_done, input logic e_ab,
                            input logic [3:0] e_sl);
      chk({tag, "_reg"},   32'(reg_out),    32'(e_reg));
      chk({tag, "_ready"}, 32'(cmd_ready),  32'(e_rdy));
      chk({tag, "_busy"},  32'(busy),       32'(e_busy));
      chk({tag, "_done"},  32'(done),       32'(e_done));
      chk({tag, "_abrt"},  32'(aborted),    32'(e_ab));
      chk({tag, "_sleft"}, 32'(steps_left), 32'(e_sl));
   endtask

   initial begin
      logic [23:0] a, b, c, z, n9;
      int busy_cycles;
      bit  saw_done;

      n_checks = 0;
      n_fail   = 0;
      a  = pk(8'd6, 8'd1, 8'd7);
      b  = pk(8'd1, 8'd7, 8'd6);
      c  = pk(8'd7, 8'd6, 8'd1);
      z  = 24'd0;
      n9 = pk(8'd9, 8'd9, 8'd9);

      // rst  v  op  st     data abrt | reg rdy busy done ab sl
      // LOAD (6,1,7)
      add(1'b0, 1'b1, L,  4'd0, a,  1'b0, a, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      add(1'b0, 1'b0, L,  4'd0, z,  1'b0, a, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      // ROT_LEFT 1
      add(1'b0, 1'b1, RL, 4'd1, z,  1'b0, a, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
      add(1'b0, 1'b0, L,  4'd0, z,  1'b0, b, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      add(1'b0, 1'b0, L,  4'd0, z,  1'b0, b, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      // reload, ROT_RIGHT 4
      add(1'b0, 1'b1, L,  4'd0, a,  1'b0, a, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      add(1'b0, 1'b0, L,  4'd0, z,  1'b0, a, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      add(1'b0, 1'b1, RR, 4'd4, z,  1'b0, a, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
      add(1'b0, 1'b0, L,  4'd0, z,  1'b0, c, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
      add(1'b0, 1'b0, L,  4'd0, z,  1'b0, b, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
      add(1'b0, 1'b0, L,  4'd0, z,  1'b0, a, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
      add(1'b0, 1'b0, L,  4'd0, z,  1'b0, c, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      add(1'b0, 1'b0, L,  4'd0, z,  1'b0, c, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      // reload, ROT_LEFT 9 with a LOAD held during ROT, abort after 2 steps
      add(1'b0, 1'b1, L,  4'd0, a,  1'b0, a, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      add(1'b0, 1'b0, L,  4'd0, z,  1'b0, a, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      add(1'b0, 1'b1, RL, 4'd9, z,  1'b0, a, 1'b0, 1'b1, 1'b0, 1'b0, 4'd9);
      add(1'b0, 1'b1, L,  4'd0, n9, 1'b0, b, 1'b0, 1'b1, 1'b0, 1'b0, 4'd8);
      add(1'b0, 1'b1, L,  4'd0, n9, 1'b0, c, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7);
      add(1'b0, 1'b0, L,  4'd0, z,  1'b1, c, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
      // abort while idle has no effect; aborted holds until the next accept
      add(1'b0, 1'b0, L,  4'd0, z,  1'b1, c, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
      // abort together with the final step: rotation suppressed
      add(1'b0, 1'b1, RL, 4'd1, z,  1'b0, c, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
      add(1'b0, 1'b0, L,  4'd0, z,  1'b1, c, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
      add(1'b0, 1'b0, L,  4'd0, z,  1'b0, c, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
      // ROT_LEFT 0, then CLEAR with cmd_valid held high throughout
      add(1'b0, 1'b1, RL, 4'd0, z,  1'b0, c, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      add(1'b0, 1'b1, CL, 4'd0, z,  1'b0, c, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      add(1'b0, 1'b1, CL, 4'd0, z,  1'b0, z, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      add(1'b0, 1'b1, L,  4'd7, a,  1'b0, z, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      add(1'b0, 1'b1, L,  4'd7, a,  1'b0, a, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      add(1'b0, 1'b0, L,  4'd0, z,  1'b0, a, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

      // reset
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = L; cmd_steps = 4'd0; load_data = 24'd0; abort = 1'b0;
      tick();
      tick();
      check_all("reset", z, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         rst       = vecs[i].rst;
         cmd_valid = vecs[i].valid;
         cmd_op    = vecs[i].op;
         cmd_steps = vecs[i].steps;
         load_data = vecs[i].data;
         abort     = vecs[i].abort;
         tick();
         check_all($sformatf("v%0d", i), vecs[i].e_reg, vecs[i].e_ready, vecs[i].e_busy,
                   vecs[i].e_done, vecs[i].e_ab, vecs[i].e_sl);
      end
      cmd_valid = 1'b0; abort = 1'b0;

      // reset during a ROT_LEFT 5 after two rotations, then immediate LOAD
      cmd_valid = 1'b1; cmd_op = RL; cmd_steps = 4'd5;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      check_all("midrot", c, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
      rst = 1'b1;
      tick();
      check_all("rstrot", z, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      rst = 1'b0; cmd_valid = 1'b1; cmd_op = L; load_data = pk(8'd1, 8'd2, 8'd3);
      tick();
      check_all("postrst", pk(8'd1, 8'd2, 8'd3), 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      cmd_valid = 1'b0;
      tick();

      // ROT_RIGHT 15 (a multiple of the ring size): bounded wait for done
      cmd_valid = 1'b1; cmd_op = RR; cmd_steps = 4'd15;
      tick();
      cmd_valid = 1'b0;
      busy_cycles = 0;
      saw_done = 1'b0;
      for (int k = 0; k < 40 && !saw_done; k++) begin
         if (busy) busy_cycles++;
         if (done) saw_done = 1'b1;
         else tick();
      end
      chk("long_done_seen", 32'(saw_done), 32'd1);
      chk("long_busy_cyc", 32'(busy_cycles), 32'd15);
      chk("long_reg", 32'(reg_out), 32'(pk(8'd1, 8'd2, 8'd3)));
      tick();
      chk("long_ready", 32'(cmd_ready), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
